player_pose: RTL and testbench

Registered player-pose tracker sitting directly downstream of the button-to-command decoder. It consumes the decoder's level outputs (`move`, `rotation[1:0]`) and acts once per command assertion. Forward moves are checked against the wall map through a request/acknowledge lookup. The block holds the authoritative grid position and heading that the ray caster reads each frame.

---
 rtl/player_pose.sv | 186 ++++++++++++++++++
 tb/tb_player_pose.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_pose.sv
// player_pose: registered grid position and heading of the player.
// It acts once per rising edge of the decoder's command levels. Rotations
// complete locally. Forward moves are range-checked first, and then checked
// against the wall map through a req/ack lookup that is bounded by a timeout.
module player_pose #(
  parameter int COORD_W       = 4,
  parameter int MAP_W         = 16,
  parameter int MAP_H         = 16,
  parameter int START_X       = 1,
  parameter int START_Y       = 1,
  parameter int START_HEADING = 0,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               move,
  input  logic [1:0]         rotation,
  output logic               map_req,
  output logic [COORD_W-1:0] map_x,
  output logic [COORD_W-1:0] map_y,
  input  logic               map_ack,
  input  logic               map_wall,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         heading,
  output logic               pose_upd,
  output logic               bumped,
  output logic               busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOOKUP = 1'b1;

  // The extra bit lets x-1 at 0 wrap to a large value and x+1 at the top
  // edge reach MAP_W, so one unsigned compare catches both ends.
  localparam int TW    = COORD_W + 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] HEAD_N = 2'd0;
  localparam logic [1:0] HEAD_E = 2'd1;
  localparam logic [1:0] HEAD_S = 2'd2;

  logic [0:0]         state_q,    state_d;
  logic               cmd_prev_q, cmd_prev_d;
  logic [COORD_W-1:0] pos_x_q,    pos_x_d;
  logic [COORD_W-1:0] pos_y_q,    pos_y_d;
  logic [1:0]         heading_q,  heading_d;
  logic               map_req_q,  map_req_d;
  logic [COORD_W-1:0] map_x_q,    map_x_d;
  logic [COORD_W-1:0] map_y_q,    map_y_d;
  logic               pose_upd_q, pose_upd_d;
  logic               bumped_q,   bumped_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;

  logic               rot_cw;
  logic               rot_ccw;
  logic               cmd_active;
  logic               cmd_edge;
  logic [TW-1:0]      tgt_x;
  logic [TW-1:0]      tgt_y;
  logic               tgt_oob;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timed_out;

  assign rot_cw     = (rotation == 2'b01);
  assign rot_ccw    = (rotation == 2'b10);
  assign cmd_active = move | rot_cw | rot_ccw;
  // Edges only count in IDLE; an edge seen during a lookup is dropped.
  assign cmd_edge   = cmd_active & ~cmd_prev_q & (state_q == IDLE);

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign timed_out  = (cnt_inc == CNT_W'(ACK_TIMEOUT));

  // Compute the forward target cell of the current heading and range-check it.
  always_comb begin
    tgt_x = {1'b0, pos_x_q};
    tgt_y = {1'b0, pos_y_q};
    case (heading_q)
      HEAD_N:  tgt_y = {1'b0, pos_y_q} - TW'(1);
      HEAD_E:  tgt_x = {1'b0, pos_x_q} + TW'(1);
      HEAD_S:  tgt_y = {1'b0, pos_y_q} + TW'(1);
      default: tgt_x = {1'b0, pos_x_q} - TW'(1);
    endcase
    tgt_oob = (tgt_x >= TW'(MAP_W)) || (tgt_y >= TW'(MAP_H));
  end

  // Next-state logic for the command FSM, the pose and the lookup handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    cmd_prev_d = cmd_active;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    heading_d  = heading_q;
    map_req_d  = map_req_q;
    map_x_d    = map_x_q;
    map_y_d    = map_y_q;
    pose_upd_d = 1'b0;
    bumped_d   = 1'b0;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_edge) begin
          if (move) begin
            if (tgt_oob) begin
              bumped_d   = 1'b1;
              pose_upd_d = 1'b1;
            end else begin
              map_x_d   = tgt_x[COORD_W-1:0];
              map_y_d   = tgt_y[COORD_W-1:0];
              map_req_d = 1'b1;
              cnt_d     = '0;
              state_d   = LOOKUP;
            end
          end else if (rot_cw) begin
            heading_d  = heading_q + 2'd1;
            pose_upd_d = 1'b1;
          end else begin
            heading_d  = heading_q - 2'd1;
            pose_upd_d = 1'b1;
          end
        end
      end
      LOOKUP: begin
        cnt_d = cnt_inc;
        // An ack that arrives on the last allowed cycle still wins over the timeout.
        if (map_ack || timed_out) begin
          map_req_d  = 1'b0;
          pose_upd_d = 1'b1;
          state_d    = IDLE;
          if (map_ack && !map_wall) begin
            pos_x_d = map_x_q;
            pos_y_d = map_y_q;
          end else begin
            bumped_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, with asynchronous reset to the start pose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_prev_q <= 1'b0;
      pos_x_q    <= COORD_W'(START_X);
      pos_y_q    <= COORD_W'(START_Y);
      heading_q  <= 2'(START_HEADING);
      map_req_q  <= 1'b0;
      map_x_q    <= '0;
      map_y_q    <= '0;
      pose_upd_q <= 1'b0;
      bumped_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop see pre-edge values,
      // whatever order these statements are written in.
      state_q    <= state_d;
      cmd_prev_q <= cmd_prev_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      heading_q  <= heading_d;
      map_req_q  <= map_req_d;
      map_x_q    <= map_x_d;
      map_y_q    <= map_y_d;
      pose_upd_q <= pose_upd_d;
      bumped_q   <= bumped_d;
      cnt_q      <= cnt_d;
    end
  end

  assign map_req  = map_req_q;
  assign map_x    = map_x_q;
  assign map_y    = map_y_q;
  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign heading  = heading_q;
  assign pose_upd = pose_upd_q;
  assign bumped   = bumped_q;
  assign busy     = (state_q == LOOKUP);

endmodule

// File: tb/tb_player_pose.sv
// tb_player_pose: drives directed and random commands into player_pose. The
// expected results come from a transaction-level pose model: the grid
// position, the heading and the expected lookup length for each command.
module tb_player_pose;

  localparam int ACK_TO = 15;
  localparam int MW     = 16;
  localparam int MH     = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       move = 1'b0;
  logic [1:0] rotation = 2'b00;
  logic       map_ack = 1'b0;
  logic       map_wall = 1'b0;
  logic       map_req;
  logic [3:0] map_x, map_y, pos_x, pos_y;
  logic [1:0] heading;
  logic       pose_upd, bumped, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference pose model.
  int mx, my, mh;
  int dx[4] = '{0, 1, 0, -1};
  int dy[4] = '{-1, 0, 1, 0};

  player_pose dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .move     (move),
    .rotation (rotation),
    .map_req  (map_req),
    .map_x    (map_x),
    .map_y    (map_y),
    .map_ack  (map_ack),
    .map_wall (map_wall),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .heading  (heading),
    .pose_upd (pose_upd),
    .bumped   (bumped),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are observed on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_pose(input string tag);
    check({tag, "_x"}, 32'(pos_x), 32'(mx));
    check({tag, "_y"}, 32'(pos_y), 32'(my));
    check({tag, "_h"}, 32'(heading), 32'(mh));
  endtask

  task automatic model_reset();
    mx = 1; my = 1; mh = 0;
  endtask

  // One rotation press, with the level held for hold cycles.
  task automatic rotate(input logic [1:0] rot, input int hold);
    move = 1'b0; rotation = 2'b00; step();
    rotation = rot;
    step();
    if (rot == 2'b01) mh = (mh + 1) % 4;
    else if (rot == 2'b10) mh = (mh + 3) % 4;
    check("rot_upd", 32'(pose_upd), (rot == 2'b01 || rot == 2'b10) ? 1 : 0);
    check("rot_bump", 32'(bumped), 0);
    check("rot_req", 32'(map_req), 0);
    check_pose("rot");
    for (int i = 1; i < hold; i++) begin
      step();
      check("rot_hold_upd", 32'(pose_upd), 0);
      check("rot_hold_h", 32'(heading), 32'(mh));
    end
    rotation = 2'b00;
    step();
    check("rot_after_upd", 32'(pose_upd), 0);
  endtask

  // One forward move. delay: req cycle on which to ack (0 = never).
  // poke: re-press rotation CW while the lookup is in flight.
  task automatic do_move(input int delay, input bit wall, input bit hold,
                         input bit poke, input logic [1:0] rot);
    int  tx, ty, reqc, exp_reqc;
    bit  oob, acked, blocked, done;
    move = 1'b0; rotation = 2'b00; step();
    tx  = mx + dx[mh];
    ty  = my + dy[mh];
    oob = (tx < 0) || (tx >= MW) || (ty < 0) || (ty >= MH);
    move = 1'b1; rotation = rot;
    step();
    if (!hold) begin move = 1'b0; rotation = 2'b00; end
    if (oob) begin
      check("oob_req", 32'(map_req), 0);
      check("oob_bump", 32'(bumped), 1);
      check("oob_upd", 32'(pose_upd), 1);
      check("oob_busy", 32'(busy), 0);
      check_pose("oob");
    end else begin
      check("mv_req", 32'(map_req), 1);
      check("mv_busy", 32'(busy), 1);
      check("mv_map_x", 32'(map_x), 32'(tx));
      check("mv_map_y", 32'(map_y), 32'(ty));
      acked    = (delay >= 1) && (delay <= ACK_TO);
      exp_reqc = acked ? delay : ACK_TO;
      blocked  = !acked || wall;
      reqc = 0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
        if (map_req) begin
          reqc++;
          if (poke && reqc == 1) begin move = 1'b0; rotation = 2'b00; end
          if (poke && reqc == 2) rotation = 2'b01;
          if (reqc > 1) begin
            check("mv_hold_x", 32'(map_x), 32'(tx));
            check("mv_hold_upd", 32'(pose_upd), 0);
          end
          if (reqc == delay) begin map_ack = 1'b1; map_wall = wall; end
          step();
          map_ack = 1'b0; map_wall = 1'b0;
        end else begin
          done = 1'b1;
        end
      end
      check("mv_lookup_ended", 32'(done), 1);
      check("mv_req_cycles", 32'(reqc), 32'(exp_reqc));
      check("mv_done_upd", 32'(pose_upd), 1);
      check("mv_done_bump", 32'(bumped), 32'(blocked));
      check("mv_done_busy", 32'(busy), 0);
      if (!blocked) begin mx = tx; my = ty; end
      check_pose("mv_done");
    end
    move = 1'b0; rotation = 2'b00;
    step();
    check("mv_after_upd", 32'(pose_upd), 0);
    check("mv_after_bump", 32'(bumped), 0);
    check("mv_after_req", 32'(map_req), 0);
    check_pose("mv_after");
  endtask

  initial begin
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", 32'(map_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_upd", 32'(pose_upd), 0);
    check("rst_map_x", 32'(map_x), 0);
    check_pose("rst");
    @(negedge clk) rst_n = 1'b1;
    step();

    // Hold-then-repress rotation and the wrap of both directions.
    rotate(2'b01, 5);
    check("rot_first", 32'(heading), 1);
    rotate(2'b01, 1);
    check("rot_second", 32'(heading), 2);
    rotate(2'b10, 1);
    rotate(2'b10, 2);
    rotate(2'b10, 1);
    check("ccw_wrap", 32'(heading), 3);
    rotate(2'b01, 1);
    check("cw_wrap", 32'(heading), 0);
    rotate(2'b11, 1);

    // Free move east, acked on the third request cycle.
    rotate(2'b01, 1);
    do_move(3, 1'b0, 1'b0, 1'b0, 2'b00);
    check("free_x", 32'(pos_x), 2);
    check("free_y", 32'(pos_y), 1);
    do_move(2, 1'b1, 1'b0, 1'b0, 2'b00);
    do_move(0, 1'b0, 1'b0, 1'b0, 2'b00);
    do_move(ACK_TO, 1'b0, 1'b0, 1'b0, 2'b00);
    do_move(1, 1'b0, 1'b1, 1'b0, 2'b10);
    do_move(4, 1'b0, 1'b0, 1'b1, 2'b00);

    // Asynchronous reset in the middle of a lookup.
    move = 1'b0; step();
    move = 1'b1; step();
    move = 1'b0;
    check("mid_req", 32'(map_req), 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_req", 32'(map_req), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check_pose("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    map_ack = 1'b1;
    step();
    map_ack = 1'b0;
    check("late_ack_upd", 32'(pose_upd), 0);
    check("late_ack_req", 32'(map_req), 0);
    check_pose("late_ack");

    // Walk to (0,0) facing north, then to the east edge.
    do_move(1, 1'b0, 1'b0, 1'b0, 2'b00);
    rotate(2'b10, 1);
    do_move(2, 1'b0, 1'b0, 1'b0, 2'b00);
    rotate(2'b01, 1);
    check("corner_x", 32'(pos_x), 0);
    check("corner_y", 32'(pos_y), 0);
    do_move(1, 1'b0, 1'b0, 1'b0, 2'b00);
    rotate(2'b01, 1);
    for (int i = 0; i < 15; i++) do_move(1, 1'b0, 1'b0, 1'b0, 2'b00);
    check("east_edge_x", 32'(pos_x), 15);
    do_move(1, 1'b0, 1'b0, 1'b0, 2'b00);

    // Random command mix.
    for (int n = 0; n < 60; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) rotate(2'b01, int'($urandom_range(1, 3)));
      else if (kind == 1) rotate(2'b10, int'($urandom_range(1, 3)));
      else do_move(int'($urandom_range(0, 18)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
